// File: rtl/seq_detect_jk.sv
// Parametrised Mealy pattern detector: KMP automaton in JK cells, overlap mode, registered match.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.

module seq_detect_jk_dff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module seq_detect_jk_jkff (
  input  logic clk,
  input  logic rst,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);
  logic w_d;
  logic w_q;

  // Characteristic equation Q+ = J~Q | ~KQ mapped onto a D cell.
  assign w_d = (i_j & ~w_q) | (~i_k & w_q);

  seq_detect_jk_dff u_dff (
    .clk (clk),
    .rst (rst),
    .i_d (w_d),
    .o_q (w_q)
  );

  assign o_q = w_q;
endmodule

module seq_detect_jk #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8,
  localparam int              SW      = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             ovl,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_cnt
);

  // Longest pattern prefix (shorter than PAT_W) that ends the string "prefix(s) then b".
  function automatic int f_next(input int s, input int b);
    logic [31:0] v_str;
    logic [31:0] v_pat;
    int          v_res;
    v_pat = 32'(PATTERN);
    v_str = ((v_pat >> (PAT_W - s)) << 1) | 32'(b);
    v_res = 0;
    for (int k = 1; k < PAT_W; k++) begin
      if (k <= s + 1 && ((v_str & ((32'd1 << k) - 32'd1)) == (v_pat >> (PAT_W - k))))
        v_res = k;
    end
    return v_res;
  endfunction

  function automatic int f_border();
    logic [31:0] v_pat;
    int          v_res;
    v_pat = 32'(PATTERN);
    v_res = 0;
    for (int k = 1; k < PAT_W; k++) begin
      if ((v_pat & ((32'd1 << k) - 32'd1)) == (v_pat >> (PAT_W - k)))
        v_res = k;
    end
    return v_res;
  endfunction

  localparam logic [SW-1:0] BORDER = SW'(f_border());
  localparam logic [SW-1:0] LAST   = SW'(PAT_W - 1);

  logic [SW-1:0] w_tbl0 [2**SW];
  logic [SW-1:0] w_tbl1 [2**SW];
  logic [SW-1:0] w_state;
  logic [SW-1:0] w_nxt;
  logic [SW-1:0] w_j;
  logic [SW-1:0] w_k;
  logic          w_match;
  logic          r_y_q;

  genvar gs;
  for (gs = 0; gs < 2**SW; gs++) begin : g_tbl
    if (gs < PAT_W) begin : g_v
      assign w_tbl0[gs] = SW'(f_next(gs, 0));
      assign w_tbl1[gs] = SW'(f_next(gs, 1));
    end else begin : g_pad
      assign w_tbl0[gs] = '0;
      assign w_tbl1[gs] = '0;
    end
  end

  assign w_match = en & (w_state == LAST) & (x == PATTERN[0]);

  always_comb begin
    w_nxt = w_state;
    if (en) begin
      if (w_match) w_nxt = ovl ? BORDER : '0;
      else         w_nxt = x ? w_tbl1[w_state] : w_tbl0[w_state];
    end
  end

  assign w_j = w_nxt & ~w_state;
  assign w_k = ~w_nxt & w_state;

  genvar gb;
  for (gb = 0; gb < SW; gb++) begin : g_st
    seq_detect_jk_jkff u_jk (
      .clk (clk),
      .rst (rst),
      .i_j (w_j[gb]),
      .i_k (w_k[gb]),
      .o_q (w_state[gb])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_y_q <= 1'b0;
    else     r_y_q <= w_match;
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Clear wins over a coincident match; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       r_cnt <= '0;
    else if (clr)                                  r_cnt <= '0;
    else if (w_match && (r_cnt != {CNT_W{1'b1}}))  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign match_cnt = r_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr;
  assign match_cnt    = '0;
`endif

  assign y     = w_match;
  assign y_q   = r_y_q;
  assign state = w_state;

endmodule
